decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised decode stage for the MIPS core.
- Buffers fetched {pc, instr} pairs in a DEPTH-entry FIFO and decodes the head entry.
- Presents a registered control bundle to execute over a valid/ready handshake.
- Replaces the purely combinational decoder: it adds buffering, stall/flush, a fully specified default decode and reserved-instruction detection.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  sync; discards all queued and output-held instructions
- in_valid  in  1  fetch offers an entry
- in_ready  out  1  queue can accept an entry
- in_pc  in  PC_W  PC of the offered instruction
- in_instr  in  32  offered instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  PC_W  PC of the decoded instruction
- out_instr  out  32  raw decoded instruction word
- out_ctrl  out  13  {memtoreg, memen, memwrite, branch, alusrc, regdst, regwrite, jump, hilo_read, hilo_write_en, jal, jr, bal}, MSB first
- out_ri  out  1  reserved instruction
- out_syscall  out  1  SYSCALL
- out_break  out  1  BREAK
- out_cp0_write  out  1  MTC0; 0 when DEC_CP0_EN is undefined
- out_cp0_read  out  1  MFC0; 0 when DEC_CP0_EN is undefined
- out_eret  out  1  ERET; 0 when DEC_CP0_EN is undefined

Behaviour:
- Reset (async, active-high): count, rd_ptr and wr_ptr = 0; out_valid = 0; every other output register = 0; in_ready = 1 after reset is released.
- in_ready = (count != DEPTH). It is registered-count based and is independent of out_ready, so no push is accepted while full even if a pop happens in the same cycle.
- Push: in_valid & in_ready & !flush writes mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
- Load: the output register loads when (!out_valid | out_ready) & count != 0 & !flush. It captures the decode of mem[rd_ptr], sets out_valid = 1, and advances rd_ptr with wrap.
- If out_ready is high and the queue is empty, out_valid falls to 0.
- Held output is stable while out_valid & !out_ready.
- Simultaneous push and load: count is unchanged.
- Latency: a push at edge N into an empty queue gives out_valid = 1 after edge N+1. There is no combinational path from in to out.
- Capacity: DEPTH + 1 instructions in flight (DEPTH in the FIFO plus the output register).
- flush: at the next edge count = 0, pointers are equal, out_valid = 0, and a push in the same cycle is dropped. flush has priority over push and load.
- Decode is combinational on the FIFO head and registered into the outputs. Every unlisted encoding gives out_ctrl = 0 and out_ri = 1; nothing holds its previous value.
- I-ALU ops (ANDI, ORI, XORI, LUI, SLTI, SLTIU, ADDI, ADDIU): alusrc = 1, regwrite = 1.
- Loads (LB, LBU, LH, LHU, LW): memtoreg = 1, memen = 1, alusrc = 1, regwrite = 1.
- Stores (SB, SH, SW): memen = 1, memwrite = 1, alusrc = 1.
- Branches (BEQ, BNE, BGTZ, BLEZ, and REGIMM BLTZ, BGEZ): branch = 1.
- BLTZAL, BGEZAL: branch = 1, regwrite = 1, bal = 1.
- J: jump = 1.
- JAL: regwrite = 1, jal = 1.
- SPECIAL ALU and shift ops, SLT, SLTU, ADD, ADDU, SUB, SUBU: regdst = 1, regwrite = 1.
- MFHI, MFLO: regdst = 1, regwrite = 1, hilo_read = 1.
- MTHI, MTLO, MULT, MULTU, DIV, DIVU: hilo_write_en = 1.
- JR: jump = 1, jr = 1.
- JALR: regdst = 1, regwrite = 1, jr = 1.
- SYSCALL: out_ctrl = 0, out_syscall = 1.
- BREAK: out_ctrl = 0, out_break = 1.
- out_ri = 0 for every listed encoding.

Optional Feature:
- Macro: DEC_CP0_EN.
- Defined, COP0 (op 010000) decodes as follows:
  - rs = 00000 (MFC0): regwrite = 1, out_cp0_read = 1.
  - rs = 00100 (MTC0): out_cp0_write = 1.
  - instr = 0x42000018 (ERET): out_eret = 1.
  - Any other COP0 encoding gives out_ri = 1.
- Undefined: all COP0 encodings give out_ri = 1; out_cp0_write, out_cp0_read and out_eret are tied to 0.

Test Plan:
- Reset, then push pc 0xBFC00000, instr 0x34010005 (ORI), with out_ready = 1. Expect out_valid after one edge, out_pc = 0xBFC00000, out_ctrl = 13'b0000101000000, out_ri = 0.
- With DEPTH = 4 and out_ready = 0, push continuously. Expect 5 entries accepted and in_ready = 0. Then raise out_ready: outputs drain in push order, one per cycle, and in_ready = 1 after the first pop.
- Push instr 0xFC000000. Expect out_ri = 1 and out_ctrl = 0. Then push 0x0000000C. Expect out_syscall = 1 and out_ri = 0.
- Queue full with out_valid = 1, assert flush together with in_valid. Next cycle: out_valid = 0, in_ready = 1, and no entry emerges afterwards.
- Push 0x40806000 (MTC0). With DEC_CP0_EN: out_cp0_write = 1, out_ri = 0. Without it: out_ri = 1, out_cp0_write = 0.
- Assert rst asynchronously mid-drain. Expect out_valid = 0 and all outputs 0 immediately, and a fresh push after release decodes correctly.

Source files
------------

// File: rtl/decode_queue.sv
// Buffered MIPS decode stage: DEPTH-entry {pc, instr} FIFO feeding a registered decode bundle.
// Optional COP0 decode (MFC0/MTC0/ERET) is enabled by defining DEC_CP0_EN.
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PC_W-1:0] in_pc,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic [12:0]     out_ctrl,
   output logic            out_ri,
   output logic            out_syscall,
   output logic            out_break,
   output logic            out_cp0_write,
   output logic            out_cp0_read,
   output logic            out_eret
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [12:0] C_MEMTOREG = 13'h1000;
   localparam logic [12:0] C_MEMEN    = 13'h0800;
   localparam logic [12:0] C_MEMWRITE = 13'h0400;
   localparam logic [12:0] C_BRANCH   = 13'h0200;
   localparam logic [12:0] C_ALUSRC   = 13'h0100;
   localparam logic [12:0] C_REGDST   = 13'h0080;
   localparam logic [12:0] C_REGWRITE = 13'h0040;
   localparam logic [12:0] C_JUMP     = 13'h0020;
   localparam logic [12:0] C_HILO_RD  = 13'h0010;
   localparam logic [12:0] C_HILO_WR  = 13'h0008;
   localparam logic [12:0] C_JAL      = 13'h0004;
   localparam logic [12:0] C_JR       = 13'h0002;
   localparam logic [12:0] C_BAL      = 13'h0001;

   // Result layout: {ctrl[12:0], ri, syscall, break, cp0_write, cp0_read, eret}
   function automatic logic [18:0] decode(input logic [31:0] instr);
      logic [12:0] c;
      logic        ri;
      logic        sc;
      logic        bk;
      logic        cw;
      logic        cr;
      logic        er;
      c  = 13'b0;
      ri = 1'b0;
      sc = 1'b0;
      bk = 1'b0;
      cw = 1'b0;
      cr = 1'b0;
      er = 1'b0;
      case (instr[31:26])
         6'h00: begin
            case (instr[5:0])
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
               6'h26, 6'h27, 6'h2a, 6'h2b:                c  = C_REGDST | C_REGWRITE;
               6'h08:                                      c  = C_JUMP | C_JR;
               6'h09:                                      c  = C_REGDST | C_REGWRITE | C_JR;
               6'h0c:                                      sc = 1'b1;
               6'h0d:                                      bk = 1'b1;
               6'h10, 6'h12:                               c  = C_REGDST | C_REGWRITE | C_HILO_RD;
               6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b:   c  = C_HILO_WR;
               default:                                    ri = 1'b1;
            endcase
         end
         6'h01: begin
            case (instr[20:16])
               5'h00, 5'h01: c  = C_BRANCH;
               5'h10, 5'h11: c  = C_BRANCH | C_REGWRITE | C_BAL;
               default:      ri = 1'b1;
            endcase
         end
         6'h02:                             c = C_JUMP;
         6'h03:                             c = C_REGWRITE | C_JAL;
         6'h04, 6'h05, 6'h06, 6'h07:        c = C_BRANCH;
         6'h08, 6'h09, 6'h0a, 6'h0b,
         6'h0c, 6'h0d, 6'h0e, 6'h0f:        c = C_ALUSRC | C_REGWRITE;
         6'h10: begin
`ifdef DEC_CP0_EN
            if (instr == 32'h4200_0018) begin
               er = 1'b1;
            end else if (instr[25:21] == 5'h00) begin
               c  = C_REGWRITE;
               cr = 1'b1;
            end else if (instr[25:21] == 5'h04) begin
               cw = 1'b1;
            end else begin
               ri = 1'b1;
            end
`else
            ri = 1'b1;
`endif
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: c = C_MEMTOREG | C_MEMEN | C_ALUSRC | C_REGWRITE;
         6'h28, 6'h29, 6'h2b:               c = C_MEMEN | C_MEMWRITE | C_ALUSRC;
         default:                           ri = 1'b1;
      endcase
      return {c, ri, sc, bk, cw, cr, er};
   endfunction

   logic [PC_W+31:0] mem_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             out_valid_r;
   logic [PC_W-1:0]  out_pc_r;
   logic [31:0]      out_instr_r;
   logic [18:0]      dec_r;

   logic             push_s;
   logic             load_s;
   logic [PC_W+31:0] head_s;
   logic [18:0]      head_dec_s;

   assign in_ready   = (count_r != FULL_CNT);
   assign push_s     = in_valid & in_ready & ~flush;
   assign load_s     = (~out_valid_r | out_ready) & (count_r != CNT_W'(0)) & ~flush;
   assign head_s     = mem_r[rd_ptr_r];
   assign head_dec_s = decode(head_s[31:0]);

   // FIFO storage write; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {in_pc, in_instr};
      end
   end

   // Queue pointers, occupancy and the registered output bundle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_r    <= PTR_W'(0);
         wr_ptr_r    <= PTR_W'(0);
         count_r     <= CNT_W'(0);
         out_valid_r <= 1'b0;
         out_pc_r    <= PC_W'(0);
         out_instr_r <= 32'h0;
         dec_r       <= 19'h0;
      end else if (flush) begin
         rd_ptr_r    <= PTR_W'(0);
         wr_ptr_r    <= PTR_W'(0);
         count_r     <= CNT_W'(0);
         out_valid_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (load_s) begin
            rd_ptr_r    <= rd_ptr_r + PTR_W'(1);
            out_valid_r <= 1'b1;
            out_pc_r    <= head_s[PC_W+31:32];
            out_instr_r <= head_s[31:0];
            dec_r       <= head_dec_s;
         end else if (out_ready) begin
            // Consumer took the bundle and nothing was queued behind it
            out_valid_r <= 1'b0;
         end
         case ({push_s, load_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign out_valid     = out_valid_r;
   assign out_pc        = out_pc_r;
   assign out_instr     = out_instr_r;
   assign out_ctrl      = dec_r[18:6];
   assign out_ri        = dec_r[5];
   assign out_syscall   = dec_r[4];
   assign out_break     = dec_r[3];
   assign out_cp0_write = dec_r[2];
   assign out_cp0_read  = dec_r[1];
   assign out_eret      = dec_r[0];
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: table-driven decode model, randomized traffic,
// directed latency/capacity/flush/reset/COP0 scenarios.
module tb_decode_queue;
   localparam int DEPTH = 4;
   localparam int PC_W  = 32;

   localparam bit [12:0] MTR = 13'h1000, MEN = 13'h0800, MWR = 13'h0400, BR = 13'h0200;
   localparam bit [12:0] ASRC = 13'h0100, RDST = 13'h0080, RW = 13'h0040, JMP = 13'h0020;
   localparam bit [12:0] HR = 13'h0010, HW = 13'h0008, JALB = 13'h0004, JRB = 13'h0002, BAL = 13'h0001;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [PC_W-1:0] in_pc = '0;
   logic [31:0]     in_instr = '0;
   logic            in_ready;
   logic            out_valid;
   logic [PC_W-1:0] out_pc;
   logic [31:0]     out_instr;
   logic [12:0]     out_ctrl;
   logic            out_ri, out_syscall, out_break, out_cp0_write, out_cp0_read, out_eret;

   decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_ctrl(out_ctrl), .out_ri(out_ri), .out_syscall(out_syscall), .out_break(out_break),
      .out_cp0_write(out_cp0_write), .out_cp0_read(out_cp0_read), .out_eret(out_eret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
      logic [12:0]     ctrl;
      logic            ri, sc, bk, cw, cr, er;
   } exp_t;

   exp_t      exp_q[$];
   int        tests = 0;
   int        fails = 0;
   int        accepted = 0;
   bit [12:0] op_tab[bit [5:0]];
   bit [12:0] fn_tab[bit [5:0]];
   bit [12:0] rt_tab[bit [4:0]];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic build_tables();
      for (int k = 8; k < 16; k++) op_tab[6'(k)] = ASRC | RW;
      for (int k = 4; k < 8; k++)  op_tab[6'(k)] = BR;
      op_tab[6'h02] = JMP;
      op_tab[6'h03] = RW | JALB;
      op_tab[6'h20] = MTR | MEN | ASRC | RW; op_tab[6'h21] = MTR | MEN | ASRC | RW;
      op_tab[6'h23] = MTR | MEN | ASRC | RW; op_tab[6'h24] = MTR | MEN | ASRC | RW;
      op_tab[6'h25] = MTR | MEN | ASRC | RW;
      op_tab[6'h28] = MEN | MWR | ASRC; op_tab[6'h29] = MEN | MWR | ASRC; op_tab[6'h2b] = MEN | MWR | ASRC;
      fn_tab[6'h00] = RDST | RW; fn_tab[6'h02] = RDST | RW; fn_tab[6'h03] = RDST | RW;
      fn_tab[6'h04] = RDST | RW; fn_tab[6'h06] = RDST | RW; fn_tab[6'h07] = RDST | RW;
      for (int k = 32; k < 40; k++) fn_tab[6'(k)] = RDST | RW;
      fn_tab[6'h2a] = RDST | RW; fn_tab[6'h2b] = RDST | RW;
      fn_tab[6'h10] = RDST | RW | HR; fn_tab[6'h12] = RDST | RW | HR;
      fn_tab[6'h11] = HW; fn_tab[6'h13] = HW;
      for (int k = 24; k < 28; k++) fn_tab[6'(k)] = HW;
      fn_tab[6'h08] = JMP | JRB;
      fn_tab[6'h09] = RDST | RW | JRB;
      rt_tab[5'h00] = BR; rt_tab[5'h01] = BR;
      rt_tab[5'h10] = BR | RW | BAL; rt_tab[5'h11] = BR | RW | BAL;
   endtask

   function automatic exp_t ref_dec(input logic [PC_W-1:0] pc, input logic [31:0] ins);
      exp_t e;
      e = '0;
      e.pc = pc;
      e.instr = ins;
      if (ins[31:26] == 6'h00) begin
         if (ins[5:0] == 6'h0c) e.sc = 1'b1;
         else if (ins[5:0] == 6'h0d) e.bk = 1'b1;
         else if (fn_tab.exists(ins[5:0])) e.ctrl = fn_tab[ins[5:0]];
         else e.ri = 1'b1;
      end else if (ins[31:26] == 6'h01) begin
         if (rt_tab.exists(ins[20:16])) e.ctrl = rt_tab[ins[20:16]];
         else e.ri = 1'b1;
      end else if (ins[31:26] == 6'h10) begin
`ifdef DEC_CP0_EN
         if (ins == 32'h4200_0018) e.er = 1'b1;
         else if (ins[25:21] == 5'd0) begin e.ctrl = RW; e.cr = 1'b1; end
         else if (ins[25:21] == 5'd4) e.cw = 1'b1;
         else e.ri = 1'b1;
`else
         e.ri = 1'b1;
`endif
      end else if (op_tab.exists(ins[31:26])) begin
         e.ctrl = op_tab[ins[31:26]];
      end else begin
         e.ri = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int          sel;
      w   = $urandom();
      sel = $urandom_range(0, 19);
      if (sel < 5) w[31:26] = 6'h00;
      else if (sel < 7) begin
         w[31:26] = 6'h01;
         if (sel == 5) w[20:16] = 5'h10 | 5'($urandom_range(0, 1));
      end else if (sel < 9) begin
         w[31:26] = 6'h10;
         w[25:21] = (sel == 7) ? 5'h00 : 5'h04;
      end else if (sel == 9) w = 32'h4200_0018;
      return w;
   endfunction

   // One clock of stimulus: record accepted pushes, forget everything on flush
   task automatic step();
      @(negedge clk);
      if (!rst && flush) exp_q.delete();
      else if (!rst && in_valid && in_ready) begin
         exp_q.push_back(ref_dec(in_pc, in_instr));
         accepted++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_and_show(input logic [PC_W-1:0] pc, input logic [31:0] ins);
      out_ready = 1'b1;
      in_valid = 1'b1; in_pc = pc; in_instr = ins;
      step();
      in_valid = 1'b0;
      step();
   endtask

   task automatic fill(input int n);
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         in_pc = 32'h1000 + 32'(i * 4);
         in_instr = rand_instr();
         step();
      end
      in_valid = 1'b0;
   endtask

   // Monitor: every completed handshake is compared against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_output: got pc %0h instr %0h, required none", out_pc, out_instr);
            end else begin
               e = exp_q.pop_front();
               chk("bundle", 128'({out_pc, out_instr, out_ctrl, out_ri, out_syscall, out_break,
                                   out_cp0_write, out_cp0_read, out_eret}), 128'(e));
            end
         end
      end
   end

   initial begin
      int seen;
      build_tables();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
      chk("reset_out_ctrl", 128'(out_ctrl), 128'(13'h0));
      rst = 1'b0;
      #1;
      chk("reset_in_ready", 128'(in_ready), 128'(1'b1));

      // Latency: push at edge N, bundle valid after N+1
      out_ready = 1'b1;
      in_valid = 1'b1; in_pc = 32'hBFC0_0000; in_instr = 32'h3401_0005;
      step();
      in_valid = 1'b0;
      chk("latency_not_yet", 128'(out_valid), 128'(1'b0));
      step();
      chk("latency_valid", 128'(out_valid), 128'(1'b1));
      chk("ori_pc", 128'(out_pc), 128'(32'hBFC0_0000));
      chk("ori_ctrl", 128'(out_ctrl), 128'(13'b0000101000000));
      chk("ori_ri", 128'(out_ri), 128'(1'b0));
      step();

      // Capacity DEPTH+1 and in-order drain
      accepted = 0;
      fill(8);
      chk("capacity_accepted", 128'(accepted), 128'(DEPTH + 1));
      chk("capacity_in_ready", 128'(in_ready), 128'(1'b0));
      out_ready = 1'b1;
      step();
      chk("first_pop_in_ready", 128'(in_ready), 128'(1'b1));
      repeat (4) step();
      chk("drain_one_per_cycle", 128'(exp_q.size()), 128'(0));
      chk("drain_out_valid", 128'(out_valid), 128'(1'b0));

      push_and_show(32'h200, 32'hFC00_0000);
      chk("unlisted_ri", 128'(out_ri), 128'(1'b1));
      chk("unlisted_ctrl", 128'(out_ctrl), 128'(13'h0));
      push_and_show(32'h204, 32'h0000_000C);
      chk("syscall_flag", 128'(out_syscall), 128'(1'b1));
      chk("syscall_ri", 128'(out_ri), 128'(1'b0));
      push_and_show(32'h208, 32'h4080_6000);
`ifdef DEC_CP0_EN
      chk("mtc0_cp0_write", 128'(out_cp0_write), 128'(1'b1));
      chk("mtc0_ri", 128'(out_ri), 128'(1'b0));
`else
      chk("mtc0_cp0_write", 128'(out_cp0_write), 128'(1'b0));
      chk("mtc0_ri", 128'(out_ri), 128'(1'b1));
`endif
      step();

      // Flush with a full queue and a simultaneous push
      fill(7);
      chk("pre_flush_full", 128'({in_ready, out_valid}), 128'(2'b01));
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h3401_0001;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 128'(out_valid), 128'(1'b0));
      chk("flush_in_ready", 128'(in_ready), 128'(1'b1));
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (out_valid) seen++;
      end
      chk("flush_nothing_emerges", 128'(seen), 128'(0));

      // Asynchronous reset mid-drain
      fill(5);
      out_ready = 1'b1;
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("async_rst_valid", 128'(out_valid), 128'(1'b0));
      chk("async_rst_outs", 128'({out_pc, out_instr, out_ctrl, out_ri, out_syscall, out_break,
                                  out_cp0_write, out_cp0_read, out_eret}), 128'(0));
      chk("async_rst_in_ready", 128'(in_ready), 128'(1'b1));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      push_and_show(32'hBFC0_0010, 32'h8C22_0004);
      chk("post_rst_lw_ctrl", 128'(out_ctrl), 128'(MTR | MEN | ASRC | RW));
      step();

      // Randomized traffic with backpressure and occasional flush
      for (int c = 0; c < 600; c++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_pc = $urandom();
         in_instr = rand_instr();
         flush = ($urandom_range(0, 49) == 0);
         out_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 6);
         step();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      chk("final_drain_empty", 128'(exp_q.size()), 128'(0));
      chk("final_out_valid", 128'(out_valid), 128'(1'b0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
